// File: rtl/rv32i_regfile_mp.sv
// Parametrised multi-read-port register file with x0 hard-zero, registered reads and a post-reset clear engine.
// Optional macro REGFILE_BYPASS_EN selects write-first forwarding; undefined gives read-first.
//
// state | meaning
// CLEAR | clear engine zeroes one entry per cycle, busy=1, reads forced to 0
// READY | normal read/write operation
module rv32i_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
    output logic [NUM_RD*XLEN-1:0]   rs_data,
    input  logic                     wr,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [XLEN-1:0]          rd,
    output logic                     busy
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] cnt;
    logic [XLEN-1:0] mem [DEPTH];
    logic            clr_en;
    logic            wr_en;
    logic            rd_upd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt == CNT_LAST) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy   = (state == CLEAR);
        clr_en = (state == CLEAR);
        wr_en  = (state == READY) && wr && (rd_addr != '0);
        rd_upd = (state == READY) && rd_en;
    end

    // One bit wider than the address so the terminal compare never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr_en) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_en) begin
                mem[cnt[ADDR_W-1:0]] <= '0;
            end else if (wr_en) begin
                mem[rd_addr] <= rd;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   val;
        logic [XLEN-1:0]   q;

        assign addr = rs_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            if (addr == '0) begin
                val = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr && (rd_addr == addr)) begin
                val = rd;
`endif
            end else begin
                val = mem[addr];
            end
        end

        // Clearing also covers the reset edge, so reads are zero throughout CLEAR.
        always_ff @(posedge clk) begin
            if (rst || clr_en) begin
                q <= '0;
            end else if (rd_upd) begin
                q <= val;
            end
        end

        assign rs_data[k*XLEN +: XLEN] = q;
    end

endmodule
